logs_pwm_decoder: RTL

LOGS_PWM_DECODER -- requirements
Module: logs_pwm_decoder

---
 rtl/logs_pwm_decoder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/logs_pwm_decoder.sv
// rtl/logs_pwm_decoder.sv - PWM bitstream decoder producing per-window duty and rising-edge samples
module logs_pwm_decoder #(
    parameter  int WINDOW    = 256,
    parameter  int EDGE_BITS = 8,
    localparam int OUT_BITS  = $clog2(WINDOW)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 pwm_in,
    output logic [OUT_BITS-1:0]  sample_data,
    output logic [EDGE_BITS-1:0] sample_edges,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overflow,
    input  logic                 clear_overflow
);

    localparam logic [OUT_BITS-1:0]  WCNT_LAST = OUT_BITS'(WINDOW - 1);
    localparam logic [OUT_BITS-1:0]  DATA_MAX  = OUT_BITS'(WINDOW - 1);
    localparam logic [OUT_BITS:0]    ACC_FULL  = (OUT_BITS + 1)'(WINDOW);
    localparam logic [EDGE_BITS-1:0] ECNT_MAX  = {EDGE_BITS{1'b1}};

    // synchronizer and edge-detect history
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic s_prev_q, s_prev_d;

    // window accumulation state
    logic [OUT_BITS-1:0]  wcnt_q, wcnt_d;
    logic [OUT_BITS:0]    acc_q, acc_d;
    logic [EDGE_BITS-1:0] ecnt_q, ecnt_d;

    // output holding register
    logic [OUT_BITS-1:0]  sample_data_q, sample_data_d;
    logic [EDGE_BITS-1:0] sample_edges_q, sample_edges_d;
    logic                 sample_valid_q, sample_valid_d;
    logic                 overflow_q, overflow_d;

    // intermediate window results
    logic                 s;
    logic                 rise;
    logic                 window_end;
    logic [OUT_BITS:0]    total;
    logic [EDGE_BITS-1:0] edges_sat;
    logic [OUT_BITS-1:0]  duty_sat;
    logic                 load;
    logic                 drop;
    logic                 xfer;

    assign s = sync2_q;

    // two-flop synchronizer plus one-cycle history of the synchronized value
    always_comb begin
        sync1_d  = pwm_in;
        sync2_d  = sync1_q;
        s_prev_d = sync2_q;
    end

    // per-window accumulation; enable low parks the window at its start
    always_comb begin
        rise       = s & ~s_prev_q;
        window_end = enable && (wcnt_q == WCNT_LAST);
        total      = acc_q + (OUT_BITS + 1)'(s);
        edges_sat  = (ecnt_q == ECNT_MAX) ? ecnt_q : ecnt_q + EDGE_BITS'(rise);
        duty_sat   = (total == ACC_FULL) ? DATA_MAX : total[OUT_BITS-1:0];

        wcnt_d = wcnt_q;
        acc_d  = acc_q;
        ecnt_d = ecnt_q;
        if (!enable || window_end) begin
            wcnt_d = '0;
            acc_d  = '0;
            ecnt_d = '0;
        end else begin
            wcnt_d = wcnt_q + 1'b1;
            acc_d  = total;
            ecnt_d = edges_sat;
        end
    end

    // valid/ready output register with drop-on-full and sticky overflow
    always_comb begin
        xfer = sample_valid_q && sample_ready;
        load = window_end && (!sample_valid_q || sample_ready);
        drop = window_end && sample_valid_q && !sample_ready;

        sample_data_d  = sample_data_q;
        sample_edges_d = sample_edges_q;
        sample_valid_d = sample_valid_q;
        overflow_d     = overflow_q;

        if (load) begin
            sample_data_d  = duty_sat;
            sample_edges_d = edges_sat;
            sample_valid_d = 1'b1;
        end else if (xfer) begin
            sample_valid_d = 1'b0;
        end

        // a drop in the same cycle as a clear keeps the flag set
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // all state registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            s_prev_q       <= 1'b0;
            wcnt_q         <= '0;
            acc_q          <= '0;
            ecnt_q         <= '0;
            sample_data_q  <= '0;
            sample_edges_q <= '0;
            sample_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            s_prev_q       <= s_prev_d;
            wcnt_q         <= wcnt_d;
            acc_q          <= acc_d;
            ecnt_q         <= ecnt_d;
            sample_data_q  <= sample_data_d;
            sample_edges_q <= sample_edges_d;
            sample_valid_q <= sample_valid_d;
            overflow_q     <= overflow_d;
        end
    end

    assign sample_data  = sample_data_q;
    assign sample_edges = sample_edges_q;
    assign sample_valid = sample_valid_q;
    assign overflow     = overflow_q;

endmodule
